lsu_bus_arbiter: RTL and testbench

//  Shares the single LSU port (st_en/addr/st_data -> ld_data) between two requesters.
//  m0 is the core pipeline; m1 is the debug/program loader.

---
 rtl/lsu_bus_arbiter_pkg.sv | 18 +
 rtl/lsu_bus_arbiter_if.sv | 52 +++++
 rtl/lsu_bus_arbiter_pick.sv | 41 ++++
 rtl/lsu_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_lsu_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_bus_arbiter_pkg.sv
// lsu_arb_pkg: shared types for the two-master LSU bus arbiter.
// Holds the FSM state encoding, the master id type and the load-latency ceiling.
package lsu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   typedef logic master_id_t;

   localparam master_id_t M0 = 1'b0;
   localparam master_id_t M1 = 1'b1;

   localparam int LD_LAT_MAX = 4;

endpackage

// File: rtl/lsu_bus_arbiter_if.sv
// lsu_bus_arbiter_if: bundles both requester ports and the LSU-side port.
// The slave modport is the arbiter's view; the master modport is the environment
// (requesters plus LSU) driving it.
interface lsu_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              m0_req_i;
   logic              m0_we_i;
   logic [ADDR_W-1:0] m0_addr_i;
   logic [DATA_W-1:0] m0_wdata_i;
   logic              m0_gnt_o;
   logic              m0_rvalid_o;
   logic [DATA_W-1:0] m0_rdata_o;

   logic              m1_req_i;
   logic              m1_we_i;
   logic [ADDR_W-1:0] m1_addr_i;
   logic [DATA_W-1:0] m1_wdata_i;
   logic              m1_gnt_o;
   logic              m1_rvalid_o;
   logic [DATA_W-1:0] m1_rdata_o;

   logic              lsu_st_en_o;
   logic [ADDR_W-1:0] lsu_addr_o;
   logic [DATA_W-1:0] lsu_st_data_o;
   logic [DATA_W-1:0] lsu_ld_data_i;

   logic              busy_o;

   modport slave (
      input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      output lsu_st_en_o, lsu_addr_o, lsu_st_data_o,
      input  lsu_ld_data_i,
      output busy_o
   );

   modport master (
      output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      input  lsu_st_en_o, lsu_addr_o, lsu_st_data_o,
      output lsu_ld_data_i,
      input  busy_o
   );

endinterface

// File: rtl/lsu_bus_arbiter_pick.sv
// lsu_arb_pick: combinational winner select between the two requesters.
// Build option LSU_ARB_RR_EN: when defined, a tie goes to the master that did not
// win last time; when undefined, m0 always beats m1 and 'last' is ignored.
module lsu_arb_pick
   import lsu_arb_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  master_id_t last,
   output logic       gnt0,
   output logic       gnt1
);

`ifdef LSU_ARB_RR_EN
   // Round-robin: a lone requester always wins; a tie goes to the previous loser.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (req0 && req1) begin
         if (last == M0) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = 1'b1;
         end
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
   end
`else
   logic unused_last;

   // Fixed priority: the core pipeline (m0) always wins a tie.
   always_comb begin
      unused_last = last;
      gnt0        = req0;
      gnt1        = req1 && !req0;
   end
`endif

endmodule

// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter: shares one LSU port between the core pipeline (m0) and the
// debug/program loader (m1). Each access runs grant -> issue -> optional load wait,
// with the load result returned as a one-cycle rvalid pulse to its owner.
// Build option LSU_ARB_RR_EN selects round-robin tie-breaking (see lsu_arb_pick).
module lsu_bus_arbiter
   import lsu_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LD_LAT = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   lsu_bus_arbiter_if.slave bus
);

   localparam logic [1:0] CNT_INIT = 2'(LD_LAT - 1);

   if (LD_LAT < 1 || LD_LAT > LD_LAT_MAX) begin : g_bad_lat
      $error("lsu_bus_arbiter: LD_LAT=%0d outside 1..%0d", LD_LAT, LD_LAT_MAX);
   end

   if ($bits(bus.m0_addr_i) != ADDR_W || $bits(bus.m0_wdata_i) != DATA_W) begin : g_bad_width
      $error("lsu_bus_arbiter: interface widths do not match ADDR_W/DATA_W");
   end

   state_t            state;
   state_t            state_next;
   logic              pick0;
   logic              pick1;
   logic              grant;
   logic              load_done;
   logic              cap_we;
   master_id_t        cap_id;
   master_id_t        last;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_wdata;
   logic [1:0]        cnt;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;

   lsu_arb_pick u_pick (
      .req0 (bus.m0_req_i),
      .req1 (bus.m1_req_i),
      .last (last),
      .gnt0 (pick0),
      .gnt1 (pick1)
   );

   // Next-state logic: grants only from IDLE, stores finish after one issue cycle,
   // loads finish when the latency has elapsed (immediately for a 1-cycle LSU).
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      load_done  = 1'b0;
      unique case (state)
         IDLE: begin
            grant = pick0 || pick1;
            if (grant) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (cap_we) begin
               state_next = IDLE;
            end else if (LD_LAT == 1) begin
               load_done  = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 2'd1) begin
               load_done  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Latch the winning request and remember who won for the next tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cap_we    <= 1'b0;
         cap_id    <= M0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         last      <= M1;
      end else if (grant) begin
         cap_we    <= pick1 ? bus.m1_we_i    : bus.m0_we_i;
         cap_addr  <= pick1 ? bus.m1_addr_i  : bus.m0_addr_i;
         cap_wdata <= pick1 ? bus.m1_wdata_i : bus.m0_wdata_i;
         cap_id    <= pick1 ? M1 : M0;
         last      <= pick1 ? M1 : M0;
      end
   end

   // Load latency counter: loaded on issue, counts down while waiting.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else if (state == ISSUE) begin
         cnt <= CNT_INIT;
      end else if (state == WAIT) begin
         cnt <= cnt - 2'd1;
      end
   end

   // Return load data to its owner only; the other master's result is left alone.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= load_done && (cap_id == M0);
         rvalid1 <= load_done && (cap_id == M1);
         if (load_done && (cap_id == M0)) begin
            rdata0 <= bus.lsu_ld_data_i;
         end
         if (load_done && (cap_id == M1)) begin
            rdata1 <= bus.lsu_ld_data_i;
         end
      end
   end

   assign bus.m0_gnt_o      = rst_ni && (state == IDLE) && pick0;
   assign bus.m1_gnt_o      = rst_ni && (state == IDLE) && pick1;
   assign bus.m0_rvalid_o   = rvalid0;
   assign bus.m1_rvalid_o   = rvalid1;
   assign bus.m0_rdata_o    = rdata0;
   assign bus.m1_rdata_o    = rdata1;
   assign bus.lsu_st_en_o   = (state == ISSUE) && cap_we;
   assign bus.lsu_addr_o    = cap_addr;
   assign bus.lsu_st_data_o = cap_wdata;
   assign bus.busy_o        = (state != IDLE);

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// tb_lsu_bus_arbiter: drives two arbiters (LD_LAT=1 and LD_LAT=3) with random
// requests and compares every cycle against a timestamp-based access model.
// Honours LSU_ARB_RR_EN the same way as the design.
`timescale 1ns/1ps
module tb_lsu_bus_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LAT_A  = 1;
   localparam int LAT_B  = 3;
   localparam int NCYC   = 3000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [1:0]        rst_n;
   logic [1:0]        req    [2];
   logic [1:0]        we     [2];
   logic [ADDR_W-1:0] maddr  [2][2];
   logic [DATA_W-1:0] mwdata [2][2];
   logic [DATA_W-1:0] ld_data[2];
   logic [1:0]        gnt    [2];
   logic [1:0]        rvalid [2];
   logic [DATA_W-1:0] rdata  [2][2];
   logic [1:0]        st_en;
   logic [1:0]        busy;
   logic [ADDR_W-1:0] lsu_addr[2];
   logic [DATA_W-1:0] st_data [2];

   lsu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus [2] ();

   for (genvar g = 0; g < 2; g++) begin : g_conn
      assign bus[g].m0_req_i      = req[g][0];
      assign bus[g].m0_we_i       = we[g][0];
      assign bus[g].m0_addr_i     = maddr[g][0];
      assign bus[g].m0_wdata_i    = mwdata[g][0];
      assign bus[g].m1_req_i      = req[g][1];
      assign bus[g].m1_we_i       = we[g][1];
      assign bus[g].m1_addr_i     = maddr[g][1];
      assign bus[g].m1_wdata_i    = mwdata[g][1];
      assign bus[g].lsu_ld_data_i = ld_data[g];
      assign gnt[g]      = {bus[g].m1_gnt_o, bus[g].m0_gnt_o};
      assign rvalid[g]   = {bus[g].m1_rvalid_o, bus[g].m0_rvalid_o};
      assign rdata[g][0] = bus[g].m0_rdata_o;
      assign rdata[g][1] = bus[g].m1_rdata_o;
      assign st_en[g]    = bus[g].lsu_st_en_o;
      assign busy[g]     = bus[g].busy_o;
      assign lsu_addr[g] = bus[g].lsu_addr_o;
      assign st_data[g]  = bus[g].lsu_st_data_o;
   end

   lsu_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LD_LAT(LAT_A)) dut_a (
      .clk_i  (clk),
      .rst_ni (rst_n[0]),
      .bus    (bus[0])
   );

   lsu_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LD_LAT(LAT_B)) dut_b (
      .clk_i  (clk),
      .rst_ni (rst_n[1]),
      .bus    (bus[1])
   );

   // Reference model: each access is a set of timestamps (issue cycle, result cycle,
   // cycle the arbiter is free again) derived from the access rules.
   int          lat      [2];
   int          free_at  [2];
   int          issue_at [2];
   int          done_at  [2];
   int          rst_at   [2];
   int          rst_hold [2];
   bit          in_rst   [2];
   bit          rst_done [2];
   bit          pend     [2][2];
   bit          cur_we   [2];
   int          cur_id   [2];
   bit          last     [2];
   logic [31:0] cur_addr [2];
   logic [31:0] cur_wdata[2];
   logic [31:0] cap_val  [2];
   logic [31:0] exp_addr [2];
   logic [31:0] exp_data [2];
   logic [31:0] exp_rdata[2][2];
   logic [1:0]  exp_gnt  [2];
   logic [31:0] mem      [2][16];
   int          mode;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset(input int i);
      free_at[i]  = 0;
      issue_at[i] = -1;
      done_at[i]  = -1;
      cur_we[i]   = 1'b0;
      cur_id[i]   = 0;
      last[i]     = 1'b1;
      exp_addr[i] = '0;
      exp_data[i] = '0;
      exp_gnt[i]  = '0;
      for (int m = 0; m < 2; m++) begin
         exp_rdata[i][m] = '0;
         pend[i][m]      = 1'b0;
         req[i][m]       = 1'b0;
      end
   endtask

   task automatic applyStimulus(input int i, input int k);
      if (in_rst[i]) begin
         if (rst_hold[i] == 0) begin
            rst_n[i]  = 1'b1;
            in_rst[i] = 1'b0;
         end else begin
            rst_hold[i]--;
         end
      end
      for (int m = 0; m < 2; m++) begin
         if (in_rst[i]) begin
            pend[i][m] = 1'b0;
         end else if (!pend[i][m]) begin
            if (mode == 0 || $urandom_range(99) < 40) begin
               pend[i][m]   = 1'b1;
               we[i][m]     = 1'($urandom_range(1));
               maddr[i][m]  = (mode == 2) ? 32'h10 : (32'($urandom_range(15)) << 2);
               mwdata[i][m] = $urandom;
            end
         end else if (mode == 1 && $urandom_range(99) < 5) begin
            pend[i][m] = 1'b0;
         end
         req[i][m] = pend[i][m];
      end
      if (!in_rst[i] && issue_at[i] >= 0 && !cur_we[i] && k == issue_at[i] + lat[i] - 1) begin
         ld_data[i] = mem[i][cur_addr[i][5:2]];
         cap_val[i] = ld_data[i];
      end else begin
         ld_data[i] = $urandom;
      end
   endtask

   task automatic compareCycle(input int i, input int k);
      bit         idle;
      int         w;
      logic [1:0] erv;
      string      p;
      p    = $sformatf("L%0d", lat[i]);
      idle = !in_rst[i] && (k >= free_at[i]);
      erv  = '0;
      exp_gnt[i] = '0;
      if (idle) begin
         if (req[i] == 2'b11) begin
`ifdef LSU_ARB_RR_EN
            w = last[i] ? 0 : 1;
`else
            w = 0;
`endif
            exp_gnt[i][w] = 1'b1;
         end else begin
            exp_gnt[i] = req[i];
         end
      end
      if (!in_rst[i] && k == done_at[i]) begin
         erv[cur_id[i]] = 1'b1;
         exp_rdata[i][cur_id[i]] = cap_val[i];
      end
      if (!in_rst[i] && k == issue_at[i]) begin
         exp_addr[i] = cur_addr[i];
         exp_data[i] = cur_wdata[i];
      end
      checkOutput({p, ".gnt"},     64'(gnt[i]), 64'(exp_gnt[i]));
      checkOutput({p, ".rvalid"},  64'(rvalid[i]), 64'(erv));
      checkOutput({p, ".rdata0"},  64'(rdata[i][0]), 64'(exp_rdata[i][0]));
      checkOutput({p, ".rdata1"},  64'(rdata[i][1]), 64'(exp_rdata[i][1]));
      checkOutput({p, ".st_en"},   64'(st_en[i]),
                  64'(!in_rst[i] && k == issue_at[i] && cur_we[i]));
      checkOutput({p, ".busy"},    64'(busy[i]), 64'(!in_rst[i] && k < free_at[i]));
      checkOutput({p, ".addr"},    64'(lsu_addr[i]), 64'(exp_addr[i]));
      checkOutput({p, ".st_data"}, 64'(st_data[i]), 64'(exp_data[i]));
   endtask

   task automatic advanceModel(input int i, input int k);
      int w;
      if (k == issue_at[i] && cur_we[i]) begin
         mem[i][cur_addr[i][5:2]] = cur_wdata[i];
      end
      if (exp_gnt[i] != 2'b00) begin
         w            = exp_gnt[i][1] ? 1 : 0;
         cur_id[i]    = w;
         cur_we[i]    = we[i][w];
         cur_addr[i]  = maddr[i][w];
         cur_wdata[i] = mwdata[i][w];
         issue_at[i]  = k + 1;
         if (cur_we[i]) begin
            done_at[i] = -1;
            free_at[i] = k + 2;
         end else begin
            done_at[i] = k + 1 + lat[i];
            free_at[i] = k + 1 + lat[i];
         end
         last[i]    = (w == 1);
         pend[i][w] = 1'b0;
      end
   endtask

   // Main sequence: drive on the falling edge, compare 1 ns later, optionally
   // yank reset mid-load, then advance the model to the next cycle.
   initial begin
      bit hit [2];
      bit any;
      lat[0]    = LAT_A;
      lat[1]    = LAT_B;
      rst_at[0] = 1500;
      rst_at[1] = 1650;
      rst_n     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         modelReset(i);
         in_rst[i]   = 1'b1;
         rst_hold[i] = 2;
         rst_done[i] = 1'b0;
         we[i]       = '0;
         ld_data[i]  = '0;
         cap_val[i]  = '0;
         cur_addr[i] = '0;
         cur_wdata[i]= '0;
         for (int m = 0; m < 2; m++) begin
            maddr[i][m]  = '0;
            mwdata[i][m] = '0;
         end
         for (int a = 0; a < 16; a++) mem[i][a] = '0;
      end

      for (int k = 0; k < NCYC; k++) begin
         @(negedge clk);
         mode = (k < 1000) ? 0 : ((k < 2000) ? 1 : 2);
         for (int i = 0; i < 2; i++) applyStimulus(i, k);
         #1;
         for (int i = 0; i < 2; i++) compareCycle(i, k);
         #1;
         any = 1'b0;
         for (int i = 0; i < 2; i++) begin
            hit[i] = !rst_done[i] && !in_rst[i] && k >= rst_at[i] && !any &&
                     issue_at[i] >= 0 && !cur_we[i] && k < done_at[i] &&
                     k >= issue_at[i] + ((lat[i] > 1) ? 1 : 0);
            if (hit[i]) begin
               rst_n[i] = 1'b0;
               any      = 1'b1;
            end
         end
         if (any) begin
            #1;
            for (int i = 0; i < 2; i++) begin
               if (hit[i]) begin
                  checkOutput("rst.st_en",  64'(st_en[i]), 64'd0);
                  checkOutput("rst.busy",   64'(busy[i]), 64'd0);
                  checkOutput("rst.rvalid", 64'(rvalid[i]), 64'd0);
                  checkOutput("rst.rdata0", 64'(rdata[i][0]), 64'd0);
                  checkOutput("rst.rdata1", 64'(rdata[i][1]), 64'd0);
                  checkOutput("rst.addr",   64'(lsu_addr[i]), 64'd0);
                  modelReset(i);
                  in_rst[i]   = 1'b1;
                  rst_hold[i] = 2;
                  rst_done[i] = 1'b1;
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (!hit[i] && !in_rst[i]) advanceModel(i, k);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
